// File: rtl/enc_scheduler_pkg.sv
// Shared types and constants for the RS encoder channel scheduler.
package enc_scheduler_pkg;

  typedef enum logic [0:0] {
    SCH_IDL,
    SCH_XFR
  } sch_state_t;

  function automatic int mes_bea(input int rs_mes_len, input int enc_sym_num);
    return (rs_mes_len + enc_sym_num - 1) / enc_sym_num;
  endfunction

  localparam int ENC_MES_BEA = mes_bea(239, 4);

endpackage

// File: rtl/enc_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo CH_NUM.
// ENC_SCH_PRIO_EN: channel 0 wins outright; the others rotate among themselves.
module enc_rr_arbiter
  import enc_scheduler_pkg::*;
#(
  parameter int CH_NUM = 4,
  localparam int CH_W = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              found,
  output logic [CH_W-1:0]   winner
);

  logic [CH_NUM-1:0] req_rr;
  logic [CH_W:0]     sum;

  always_comb begin
    req_rr = req;
`ifdef ENC_SCH_PRIO_EN
    req_rr[0] = 1'b0;
`endif
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      sum = {1'b0, ptr} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(CH_NUM)) sum = sum - (CH_W+1)'(CH_NUM);
      if (!found && req_rr[sum[CH_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[CH_W-1:0];
      end
    end
`ifdef ENC_SCH_PRIO_EN
    if (req[0]) begin
      found  = 1'b1;
      winner = '0;
    end
`endif
  end

endmodule

// File: rtl/enc_scheduler.sv
// Grants the shared RS encoder to one channel per whole message, re-arbitrating at codeword ends.
// ENC_SCH_PRIO_EN: channel 0 strict priority, rr_ptr only moves on grants to channels 1..CH_NUM-1.
module enc_scheduler
  import enc_scheduler_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int ENC_SYM_NUM = 4,
  parameter int RS_MES_LEN  = 239,
  parameter int SYM_WID     = 8,
  localparam int MES_BEA = mes_bea(RS_MES_LEN, ENC_SYM_NUM),
  localparam int CH_W    = $clog2(CH_NUM),
  localparam int CNT_W   = $clog2(MES_BEA),
  localparam int DAT_W   = ENC_SYM_NUM * SYM_WID
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CH_NUM-1:0]              ch_valid,
  input  logic [CH_NUM-1:0][DAT_W-1:0]   ch_data,
  output logic [CH_NUM-1:0]              ch_ready,
  input  logic                           enc_ready,
  output logic                           enc_valid,
  output logic [DAT_W-1:0]               enc_data,
  output logic                           enc_first,
  output logic                           enc_last,
  output logic [CH_W-1:0]                enc_ch,
  output logic                           sch_busy
);

  sch_state_t       state, state_nxt;
  logic [CH_W-1:0]  grant, grant_nxt;
  logic [CH_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [CH_W-1:0]  grant_inc, rr_adv, arb_ptr, arb_winner;
  logic             arb_found;

  assign grant_inc = (grant == CH_W'(CH_NUM-1)) ? '0 : grant + 1'b1;
`ifdef ENC_SCH_PRIO_EN
  assign rr_adv = (grant == '0) ? rr_ptr : grant_inc;
`else
  assign rr_adv = grant_inc;
`endif
  // In XFER the only arbitration point is the last beat, which already uses the advanced pointer.
  assign arb_ptr = (state == SCH_XFR) ? rr_adv : rr_ptr;

  enc_rr_arbiter #(.CH_NUM(CH_NUM)) u_arb (
    .req    (ch_valid),
    .ptr    (arb_ptr),
    .found  (arb_found),
    .winner (arb_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SCH_IDL;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    enc_valid    = 1'b0;
    enc_data     = '0;
    ch_ready     = '0;
    enc_ch       = '0;
    enc_first    = 1'b0;
    enc_last     = 1'b0;
    sch_busy     = (state == SCH_XFR);
    case (state)
      SCH_IDL: begin
        if (arb_found) begin
          state_nxt    = SCH_XFR;
          grant_nxt    = arb_winner;
          beat_cnt_nxt = '0;
        end
      end
      SCH_XFR: begin
        enc_valid       = ch_valid[grant];
        enc_data        = ch_data[grant];
        ch_ready[grant] = enc_ready;
        enc_ch          = grant;
        enc_first       = (beat_cnt == '0);
        enc_last        = (beat_cnt == CNT_W'(MES_BEA-1));
        if (enc_valid && enc_ready) begin
          if (enc_last) begin
            beat_cnt_nxt = '0;
            rr_ptr_nxt   = rr_adv;
            if (arb_found) grant_nxt = arb_winner;
            else           state_nxt = SCH_IDL;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = SCH_IDL;
    endcase
  end

endmodule

// File: doc/enc_scheduler.md
Name: enc_scheduler

Overview:
- Shares one RS encoder datapath between CH_NUM independent message sources.
- Grants the encoder to one channel for exactly one message (MES_BEA beats), then re-arbitrates round-robin.
- Sits between the channel ingress FIFOs and the encoder input.
- Never preempts a message: codeword boundaries are the only switch points.

Parameters:
- CH_NUM, 4: number of requesting channels (2..16).
- ENC_SYM_NUM, 4: symbols per beat (same meaning as the encoder).
- RS_MES_LEN, 239: message symbols per codeword.
- SYM_WID, 8: bits per symbol.
- MES_BEA, derived: ceil(RS_MES_LEN / ENC_SYM_NUM) = 60 beats per message.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ch_valid  in  CH_NUM  per-channel beat valid.
- ch_data  in  CH_NUM x ENC_SYM_NUM*SYM_WID  per-channel beat data.
- ch_ready  out  CH_NUM  per-channel beat accept.
- enc_ready  in  1  encoder can accept a beat this cycle (low while the encoder stalls).
- enc_valid  out  1  beat presented to the encoder.
- enc_data  out  ENC_SYM_NUM*SYM_WID  muxed beat data.
- enc_first  out  1  beat 0 of a message.
- enc_last  out  1  beat MES_BEA-1 of a message.
- enc_ch  out  $clog2(CH_NUM)  channel id of the current beat.
- sch_busy  out  1  grant held (state XFER).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. Reset is sampled at posedge clk and overrides everything.
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
  - All outputs 0: ch_ready=0, enc_valid=0, enc_first=0, enc_last=0, enc_ch=0, sch_busy=0.
  - enc_data is don't-care when enc_valid=0. It is driven as 0.
- FSM states:
  - IDLE: no grant.
  - XFER: grant held on channel grant.
- IDLE:
  - Pick winner = first channel with ch_valid=1, searching from rr_ptr upward, modulo CH_NUM.
  - If a winner exists, register grant=winner and beat_cnt=0, then go to XFER.
  - No data moves in IDLE, so request-to-first-accept latency is 1 cycle.
- XFER datapath (combinational):
  - enc_valid = ch_valid[grant].
  - enc_data = ch_data[grant].
  - ch_ready[grant] = enc_ready. All other ch_ready = 0.
  - enc_ch = grant.
  - enc_first = (beat_cnt==0).
  - enc_last = (beat_cnt==MES_BEA-1).
- Transfer: a beat transfers when enc_valid && enc_ready. Each transfer increments beat_cnt.
- Message end: on the transfer with enc_last=1:
  - beat_cnt <= 0.
  - rr_ptr <= grant+1, wrapping at CH_NUM to 0.
  - Arbitrate in the same cycle using the new pointer value (grant+1), excluding nothing.
  - If a winner exists, stay in XFER with the new grant (zero bubble). Otherwise go to IDLE.
- Held grant:
  - If the granted channel drops ch_valid mid-message, the grant is held and enc_valid=0. There is no timeout and no preemption.
  - If enc_ready=0, nothing advances and data must stay stable.
- Widths: beat_cnt is $clog2(MES_BEA) bits. It never exceeds MES_BEA-1.
- Boundaries:
  - A single requester re-wins back-to-back.
  - With all channels requesting, grants go 0,1,2,3,0.
  - A rst asserted mid-message aborts the message. The encoder side must also be reset in the same cycle.
- Invariant: at most one ch_ready bit is high in any cycle.

Optional Feature:
- Macro: ENC_SCH_PRIO_EN.
- Defined: channel 0 is strict priority. At every arbitration point, if ch_valid[0]=1, channel 0 wins regardless of rr_ptr. Channels 1..CH_NUM-1 round-robin among themselves, and rr_ptr only advances on their grants.
- Undefined: plain round-robin as above.

Decomposition:
- Package/include (encoder.vh):
  - typedef enum SCH_STATE {SCH_IDL, SCH_XFR}.
  - constant ENC_MES_BEA = (RS_MES_LEN + ENC_SYM_NUM - 1) / ENC_SYM_NUM.
- Sub-module enc_rr_arbiter:
  - Combinational.
  - Inputs: req[CH_NUM], ptr.
  - Outputs: found, winner.
  - Instantiated once in enc_scheduler.

Test Plan:
- Reset, then ch_valid=4'b0010 with enc_ready=1 held:
  - enc_valid first high 1 cycle later with enc_ch=1, enc_first=1.
  - 60 beats follow, enc_last on beat 60.
  - Then IDLE, with rr_ptr=2.
- All four channels valid continuously with enc_ready=1:
  - Grant order 0,1,2,3,0.
  - Zero idle cycles between messages.
  - The ch_ready one-hot check passes.
- Granted channel 2 drops ch_valid for 5 cycles at beat 10 while channel 3 is valid:
  - enc_valid=0 for those 5 cycles.
  - enc_ch stays 2.
  - beat_cnt resumes at 10.
- enc_ready toggling 1,0,1,0 during a message:
  - Exactly 60 transfers.
  - enc_data and enc_ch stable while enc_ready=0.
- rst asserted at beat 30 of channel 1:
  - Next cycle all outputs are 0 and state is IDLE.
  - The subsequent grant goes to the lowest valid channel (rr_ptr=0).
- ENC_SCH_PRIO_EN defined, all channels valid:
  - Order 0,0,0 while ch_valid[0]=1.
  - Dropping ch_valid[0] gives 1,2,3.
  - Re-asserting ch_valid[0] wins at the next boundary.
